pipe_hazard_ctrl: RTL and testbench

Parametrised hazard and pipeline-control unit for the 5-stage RISC-V core (IF, ID, EX, MEM, WB; branch resolved in MEM). It holds its own scoreboard of the destination registers in flight in EX, MEM and WB. From that scoreboard it generates:
- load-use and RAW stalls;
- ID/EX bubbles;
- registered ALU operand-forwarding selects;
- a multi-cycle flush after a taken branch.

It replaces the fixed single-cycle flush path and the externally driven `stall` of the current top level.

---
 rtl/pipe_hazard_ctrl.sv | 170 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Hazard and pipeline-control unit for a 5-stage RISC-V core (IF, ID, EX,
// MEM, WB; branches resolve in MEM). A private scoreboard tracks the
// destinations in flight in EX, MEM and WB and drives stall, bubble, flush
// and operand-forwarding decisions from it.
//
// Optional feature macro: PIPE_HAZ_FWD_EN
//   defined   : EX/MEM and MEM/WB forwarding; only load-use stalls.
//   undefined : forward selects tied to 00; any RAW on an EX or MEM producer
//               stalls until that producer reaches WB.
//
// Ports
//   clk                  in  rising-edge clock
//   start                in  asynchronous active-low reset
//   ext_stall_i          in  external freeze
//   id_valid_i           in  ID stage holds a real instruction
//   id_rs1_i, id_rs2_i   in  ID source registers
//   id_rs1_used_i/rs2    in  source actually read
//   id_rd_i              in  ID destination register
//   id_regwrite_i        in  ID instruction writes rd
//   id_memread_i         in  ID instruction is a load
//   br_taken_i           in  taken branch in MEM
//   pc_stall_o           out hold PC
//   ifid_stall_o         out hold IF/ID
//   idex_bubble_o        out load NOP into ID/EX
//   flush_o              out clear IF/ID, ID/EX, EX/MEM
//   fwd_a_o, fwd_b_o     out EX operand select (00 RF, 01 EX/MEM, 10 MEM/WB)
//   stall_cnt_o          out saturating hazard-stall cycle count
//
// state  | meaning
// IDLE   | no hazard, no flush in progress
// HSTALL | previous cycle inserted a hazard bubble
// FLUSH  | multi-cycle flush running; flush_cnt = cycles left after this one
module pipe_hazard_ctrl #(
  parameter int RA_W      = 5,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 16
) (
  input  logic            clk,
  input  logic            start,
  input  logic            ext_stall_i,
  input  logic            id_valid_i,
  input  logic [RA_W-1:0] id_rs1_i,
  input  logic [RA_W-1:0] id_rs2_i,
  input  logic            id_rs1_used_i,
  input  logic            id_rs2_used_i,
  input  logic [RA_W-1:0] id_rd_i,
  input  logic            id_regwrite_i,
  input  logic            id_memread_i,
  input  logic            br_taken_i,
  output logic            pc_stall_o,
  output logic            ifid_stall_o,
  output logic            idex_bubble_o,
  output logic            flush_o,
  output logic [1:0]      fwd_a_o,
  output logic [1:0]      fwd_b_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_HSTALL, S_FLUSH} state_t;

  localparam logic [3:0] FLUSH_RELOAD = 4'((FLUSH_CYC > 1) ? FLUSH_CYC - 2 : 0);

  state_t          state;
  logic [3:0]      flush_cnt;

  logic            ex_v, ex_rw, ex_mr;
  logic [RA_W-1:0] ex_rd;
  logic            mem_v, mem_rw, mem_mr;
  logic [RA_W-1:0] mem_rd;
  logic            wb_v, wb_rw, wb_mr;
  logic [RA_W-1:0] wb_rd;

  logic ex_prod, mem_prod;
  logic rs1_ex, rs2_ex, rs1_mem, rs2_mem;
  logic hazard, load_ex;

  // The WB slot and MEM memread never influence a decision: the register
  // file resolves WB write-before-read, and only a load in EX needs a stall.
  logic unused_sb;
  assign unused_sb = ^{wb_v, wb_rw, wb_mr, wb_rd, mem_mr, ex_mr};

  assign ex_prod  = ex_v  & ex_rw  & (ex_rd  != '0);
  assign mem_prod = mem_v & mem_rw & (mem_rd != '0);

  assign rs1_ex  = id_rs1_used_i & ex_prod  & (id_rs1_i == ex_rd);
  assign rs2_ex  = id_rs2_used_i & ex_prod  & (id_rs2_i == ex_rd);
  assign rs1_mem = id_rs1_used_i & mem_prod & (id_rs1_i == mem_rd);
  assign rs2_mem = id_rs2_used_i & mem_prod & (id_rs2_i == mem_rd);

`ifdef PIPE_HAZ_FWD_EN
  assign hazard = id_valid_i & ex_mr & (rs1_ex | rs2_ex);
`else
  assign hazard = id_valid_i & (rs1_ex | rs2_ex | rs1_mem | rs2_mem);
`endif

  // A freeze masks everything; a flush then masks the hazard response.
  assign flush_o       = ~ext_stall_i & (br_taken_i | (state == S_FLUSH));
  assign idex_bubble_o = ~ext_stall_i & hazard & ~flush_o;
  assign pc_stall_o    = ext_stall_i | idex_bubble_o;
  assign ifid_stall_o  = pc_stall_o;
  assign load_ex       = id_valid_i & ~idex_bubble_o & ~flush_o;

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      ex_v   <= 1'b0; ex_rd  <= '0; ex_rw  <= 1'b0; ex_mr  <= 1'b0;
      mem_v  <= 1'b0; mem_rd <= '0; mem_rw <= 1'b0; mem_mr <= 1'b0;
      wb_v   <= 1'b0; wb_rd  <= '0; wb_rw  <= 1'b0; wb_mr  <= 1'b0;
    end else if (!ext_stall_i) begin
      wb_v   <= mem_v; wb_rd  <= mem_rd; wb_rw  <= mem_rw; wb_mr  <= mem_mr;
      mem_v  <= ex_v;  mem_rd <= ex_rd;  mem_rw <= ex_rw;  mem_mr <= ex_mr;
      ex_v   <= load_ex;
      ex_rd  <= load_ex ? id_rd_i : '0;
      ex_rw  <= load_ex & id_regwrite_i;
      ex_mr  <= load_ex & id_memread_i;
    end
  end

`ifdef PIPE_HAZ_FWD_EN
  logic [1:0] sel_a, sel_b, fwd_a_q, fwd_b_q;

  // EX producer wins over MEM: it holds the younger value of rd.
  assign sel_a = rs1_ex ? 2'b01 : (rs1_mem ? 2'b10 : 2'b00);
  assign sel_b = rs2_ex ? 2'b01 : (rs2_mem ? 2'b10 : 2'b00);

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else if (!ext_stall_i) begin
      fwd_a_q <= load_ex ? sel_a : 2'b00;
      fwd_b_q <= load_ex ? sel_b : 2'b00;
    end
  end

  assign fwd_a_o = fwd_a_q;
  assign fwd_b_o = fwd_b_q;
`else
  assign fwd_a_o = 2'b00;
  assign fwd_b_o = 2'b00;
`endif

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      stall_cnt_o <= '0;
    end else if (idex_bubble_o && !(&stall_cnt_o)) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      state     <= S_IDLE;
      flush_cnt <= '0;
    end else if (!ext_stall_i) begin
      if (br_taken_i) begin
        // A branch (also one arriving mid-flush) restarts the full length.
        flush_cnt <= FLUSH_RELOAD;
        state     <= (FLUSH_CYC > 1) ? S_FLUSH : S_IDLE;
      end else if (state == S_FLUSH && flush_cnt != '0) begin
        flush_cnt <= flush_cnt - 1'b1;
      end else if (idex_bubble_o) begin
        state <= S_HSTALL;
      end else begin
        state <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int RA_W      = 5;
  localparam int FLUSH_CYC = 3;
  localparam int CNT_W     = 4;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

`ifdef PIPE_HAZ_FWD_EN
  localparam int LU_STALLS = 1;
  localparam int LU_FWD_B  = 2;
`else
  localparam int LU_STALLS = 2;
  localparam int LU_FWD_B  = 0;
`endif

  typedef struct {
    bit       v;
    bit [4:0] rs1;
    bit       u1;
    bit [4:0] rs2;
    bit       u2;
    bit [4:0] rd;
    bit       rw;
    bit       mr;
  } ins_t;

  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       rw;
    bit       mr;
  } slot_t;

  logic clk, start, ext_stall_i, id_valid_i;
  logic [RA_W-1:0] id_rs1_i, id_rs2_i, id_rd_i;
  logic id_rs1_used_i, id_rs2_used_i, id_regwrite_i, id_memread_i, br_taken_i;
  logic pc_stall_o, ifid_stall_o, idex_bubble_o, flush_o;
  logic [1:0] fwd_a_o, fwd_b_o;
  logic [CNT_W-1:0] stall_cnt_o;

  pipe_hazard_ctrl #(.RA_W(RA_W), .FLUSH_CYC(FLUSH_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .start(start), .ext_stall_i(ext_stall_i), .id_valid_i(id_valid_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
    .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
    .br_taken_i(br_taken_i), .pc_stall_o(pc_stall_o), .ifid_stall_o(ifid_stall_o),
    .idex_bubble_o(idex_bubble_o), .flush_o(flush_o),
    .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .stall_cnt_o(stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: list of instructions in flight (0 = EX, 1 = MEM, 2 = WB),
  // remaining flush cycles, stall count, and the forward selects of EX.
  slot_t m_pipe[3];
  int    m_flush_left;
  int    m_cnt;
  int    m_fa, m_fb;

  ins_t cur_i;
  bit   cur_br, cur_ext;
  bit   e_flush, e_bub, e_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ins_t mk(bit v, bit [4:0] rs1, bit u1, bit [4:0] rs2, bit u2,
                              bit [4:0] rd, bit rw, bit mr);
    ins_t i;
    i.v = v; i.rs1 = rs1; i.u1 = u1; i.rs2 = rs2; i.u2 = u2;
    i.rd = rd; i.rw = rw; i.mr = mr;
    return i;
  endfunction

  function automatic ins_t nop();
    return mk(0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic bit m_prod(int k);
    return m_pipe[k].v && m_pipe[k].rw && (m_pipe[k].rd != 0);
  endfunction

  function automatic bit m_reads(int k);
    return (cur_i.u1 && cur_i.rs1 == m_pipe[k].rd) || (cur_i.u2 && cur_i.rs2 == m_pipe[k].rd);
  endfunction

  function automatic bit m_hazard();
    if (!cur_i.v) return 0;
`ifdef PIPE_HAZ_FWD_EN
    return m_prod(0) && m_pipe[0].mr && m_reads(0);
`else
    return (m_prod(0) && m_reads(0)) || (m_prod(1) && m_reads(1));
`endif
  endfunction

  function automatic int m_sel(bit [4:0] rs, bit used);
    if (!used) return 0;
    if (m_prod(0) && m_pipe[0].rd == rs) return 1;
    if (m_prod(1) && m_pipe[1].rd == rs) return 2;
    return 0;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 3; k++) m_pipe[k] = '{0, 0, 0, 0};
    m_flush_left = 0;
    m_cnt = 0;
    m_fa = 0;
    m_fb = 0;
  endtask

  task automatic drive(input ins_t i, input bit br, input bit ext);
    cur_i = i; cur_br = br; cur_ext = ext;
    id_valid_i = i.v; id_rs1_i = i.rs1; id_rs2_i = i.rs2;
    id_rs1_used_i = i.u1; id_rs2_used_i = i.u2; id_rd_i = i.rd;
    id_regwrite_i = i.rw; id_memread_i = i.mr;
    br_taken_i = br; ext_stall_i = ext;
  endtask

  task automatic sample();
    @(negedge clk);
    e_flush = !cur_ext && (cur_br || m_flush_left > 0);
    e_bub   = !cur_ext && m_hazard() && !e_flush;
    e_stall = cur_ext || e_bub;
    chk("flush", flush_o, e_flush);
    chk("pc_stall", pc_stall_o, e_stall);
    chk("ifid_stall", ifid_stall_o, e_stall);
    chk("bubble", idex_bubble_o, e_bub);
    chk("fwd_a", fwd_a_o, m_fa);
    chk("fwd_b", fwd_b_o, m_fb);
    chk("stall_cnt", stall_cnt_o, m_cnt);
  endtask

  task automatic advance();
    bit load;
    int nfa, nfb;
    if (!cur_ext) begin
      if (e_bub && m_cnt < CNT_MAX) m_cnt++;
      if (cur_br) m_flush_left = FLUSH_CYC - 1;
      else if (m_flush_left > 0) m_flush_left--;
      load = cur_i.v && !e_bub && !e_flush;
`ifdef PIPE_HAZ_FWD_EN
      nfa = load ? m_sel(cur_i.rs1, cur_i.u1) : 0;
      nfb = load ? m_sel(cur_i.rs2, cur_i.u2) : 0;
`else
      nfa = 0;
      nfb = 0;
`endif
      m_pipe[2] = m_pipe[1];
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = load ? '{1, cur_i.rd, cur_i.rw, cur_i.mr} : '{0, 0, 0, 0};
      m_fa = nfa;
      m_fb = nfb;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input ins_t i, input bit br, input bit ext);
    drive(i, br, ext);
    sample();
    advance();
  endtask

  // Present an instruction until it leaves ID, as the IF/ID register would.
  task automatic issue_hold(input ins_t i);
    bit done = 0;
    for (int k = 0; k < 6 && !done; k++) begin
      step(i, 0, 0);
      done = !e_stall;
    end
    if (!done) begin
      total++;
      bad++;
      $error("FAIL hold_timeout observed=stalled expected=released");
    end
  endtask

  task automatic do_reset();
    drive(nop(), 0, 0);
    start = 1'b0;
    m_reset();
    #1;
    chk("rst_flush", flush_o, 0);
    chk("rst_pc_stall", pc_stall_o, 0);
    chk("rst_bubble", idex_bubble_o, 0);
    chk("rst_fwd_a", fwd_a_o, 0);
    chk("rst_fwd_b", fwd_b_o, 0);
    chk("rst_cnt", stall_cnt_o, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    start = 1'b1;
  endtask

  function automatic ins_t rnd_ins();
    return mk($urandom_range(0, 7) != 0,
              5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
              $urandom_range(0, 2) == 0);
  endfunction

  task automatic random_run(input int n);
    ins_t i = rnd_ins();
    bit br = 0, ext = 0;
    for (int c = 0; c < n; c++) begin
      step(i, br, ext);
      if (cur_ext) begin
        ext = $urandom_range(0, 2) == 0;
      end else if (e_bub) begin
        br  = $urandom_range(0, 15) == 0;
        ext = $urandom_range(0, 11) == 0;
      end else begin
        i   = rnd_ins();
        br  = $urandom_range(0, 15) == 0;
        ext = $urandom_range(0, 11) == 0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved_cnt;
    int held_fa;

    start = 1'b1;
    drive(nop(), 0, 0);
    #2;
    do_reset();

    // Load-use: lw x6, then a reader of x6 in rs2.
    step(mk(1, 1, 1, 0, 0, 6, 1, 1), 0, 0);
    issue_hold(mk(1, 2, 1, 6, 1, 8, 1, 0));
    drive(nop(), 0, 0);
    sample();
    chk("lu_fwd_b", fwd_b_o, LU_FWD_B);
    chk("lu_cnt", stall_cnt_o, LU_STALLS);
    advance();
    repeat (3) step(nop(), 0, 0);

`ifdef PIPE_HAZ_FWD_EN
    // add x5 followed directly by a reader: forward from EX/MEM.
    step(mk(1, 1, 1, 2, 1, 5, 1, 0), 0, 0);
    drive(mk(1, 5, 1, 3, 1, 9, 1, 0), 0, 0);
    sample();
    chk("fwd_ex_nostall", pc_stall_o, 0);
    advance();
    drive(nop(), 0, 0);
    sample();
    chk("fwd_ex_sel", fwd_a_o, 1);
    advance();
    // One independent instruction in between: forward from MEM/WB.
    step(mk(1, 1, 1, 2, 1, 5, 1, 0), 0, 0);
    step(mk(1, 1, 1, 0, 0, 10, 1, 0), 0, 0);
    drive(mk(1, 5, 1, 3, 1, 9, 1, 0), 0, 0);
    sample();
    chk("fwd_mem_nostall", pc_stall_o, 0);
    advance();
    drive(nop(), 0, 0);
    sample();
    chk("fwd_mem_sel", fwd_a_o, 2);
    advance();
`else
    // Back-to-back dependent ALU ops: two stall cycles, no forwarding.
    step(mk(1, 1, 1, 2, 1, 5, 1, 0), 0, 0);
    drive(mk(1, 5, 1, 5, 1, 9, 1, 0), 0, 0);
    sample();
    chk("nofwd_stall1", pc_stall_o, 1);
    chk("nofwd_fwd_a1", fwd_a_o, 0);
    advance();
    sample();
    chk("nofwd_stall2", pc_stall_o, 1);
    chk("nofwd_fwd_b2", fwd_b_o, 0);
    advance();
    sample();
    chk("nofwd_release", pc_stall_o, 0);
    advance();
    drive(nop(), 0, 0);
    sample();
    chk("nofwd_fwd_a3", fwd_a_o, 0);
    chk("nofwd_fwd_b3", fwd_b_o, 0);
    advance();
`endif
    repeat (3) step(nop(), 0, 0);

    // Branch pulse arriving during a load-use stall.
    step(mk(1, 1, 1, 0, 0, 6, 1, 1), 0, 0);
    saved_cnt = m_cnt;
    drive(mk(1, 2, 1, 6, 1, 8, 1, 0), 1, 0);
    sample();
    chk("br_flush0", flush_o, 1);
    chk("br_nostall", pc_stall_o, 0);
    chk("br_nobubble", idex_bubble_o, 0);
    advance();
    drive(nop(), 0, 0);
    sample();
    chk("br_flush1", flush_o, 1);
    advance();
    sample();
    chk("br_flush2", flush_o, 1);
    advance();
    sample();
    chk("br_flush_end", flush_o, 0);
    chk("br_cnt_same", stall_cnt_o, saved_cnt);
    advance();

    // Freeze for 4 cycles with a forwarding case pending and a branch held.
    repeat (3) step(nop(), 0, 0);
    step(mk(1, 1, 1, 2, 1, 5, 1, 0), 0, 0);
    issue_hold(mk(1, 5, 1, 3, 1, 9, 1, 0));
    held_fa = m_fa;
    for (int k = 0; k < 4; k++) begin
      drive(mk(1, 5, 1, 5, 1, 11, 1, 0), 1, 1);
      sample();
      chk("frz_fwd_a", fwd_a_o, held_fa);
      chk("frz_stall", pc_stall_o, 1);
      chk("frz_noflush", flush_o, 0);
      chk("frz_nobubble", idex_bubble_o, 0);
      advance();
    end
    drive(mk(1, 5, 1, 5, 1, 11, 1, 0), 1, 0);
    sample();
    chk("frz_release_fwd_a", fwd_a_o, held_fa);
    chk("frz_release_flush", flush_o, 1);
    advance();
    repeat (4) step(nop(), 0, 0);

    random_run(250);

    // Reset dropped into the middle of a flush.
    repeat (2) step(nop(), 0, 0);
    step(nop(), 1, 0);
    drive(nop(), 0, 0);
    #2;
    do_reset();

    // x0 as a destination never stalls.
    step(mk(1, 1, 1, 0, 0, 0, 1, 1), 0, 0);
    drive(mk(1, 0, 1, 0, 1, 9, 1, 0), 0, 0);
    sample();
    chk("x0_nostall", pc_stall_o, 0);
    chk("x0_nobubble", idex_bubble_o, 0);
    advance();

    // Drive the stall counter past its maximum.
    for (int k = 0; k < 20; k++) begin
      step(mk(1, 1, 1, 0, 0, 7, 1, 1), 0, 0);
      issue_hold(mk(1, 7, 1, 7, 1, 12, 1, 0));
    end
    drive(nop(), 0, 0);
    sample();
    chk("cnt_saturated", stall_cnt_o, CNT_MAX);
    advance();

    random_run(150);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
